// File: rtl/led_show_pkg.sv
// led_show_pkg: shared modes, states and pattern helpers for the LED show controller.
package led_show_pkg;
  typedef enum logic [1:0] {WALK, BOUNCE, FILL, BLINK} mode_e;
  typedef enum logic [1:0] {IDLE, RUN, SWITCH, PAUSE} state_e;
  localparam logic [7:0] BOUNCE_BOT = 8'h01;
  localparam logic [7:0] BOUNCE_TOP = 8'h80;
  function automatic logic [7:0] start_pattern(mode_e m);
    return (m == WALK || m == BOUNCE) ? 8'h01 : 8'h00;
  endfunction
  function automatic logic [7:0] next_pattern(mode_e m, logic [7:0] led, logic up);
    case (m)
      WALK:    return {led[6:0], led[7]};
      BOUNCE:  return up ? led << 1 : led >> 1;
      FILL:    return (led == 8'hff) ? 8'h00 : {led[6:0], 1'b1};
      default: return ~led;
    endcase
  endfunction
  // Bounce reverses on reaching either end; other modes carry the flag unused.
  function automatic logic next_dir(logic [7:0] nxt, logic up);
    return (nxt == BOUNCE_TOP) ? 1'b0 : (nxt == BOUNCE_BOT) ? 1'b1 : up;
  endfunction
endpackage

// File: rtl/led_step_timer.sv
// led_step_timer: prescaled step counter; tick flags the terminal count of the period.
module led_step_timer #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic [CNT_W-1:0] period,
  output logic             tick
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb begin
    tick = cnt_q == period - CNT_W'(1);
    cnt_d = clr ? '0 : !en ? cnt_q : tick ? '0 : cnt_q + CNT_W'(1);
  end
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/led_show_controller.sv
// led_show_controller: sequences the 8-bit LED bank through four patterns, switching
// to a newly offered config only at a pattern boundary.
module led_show_controller
  import led_show_pkg::*;
#(
  parameter int               CNT_W      = 24,
  parameter logic [CNT_W-1:0] BASE_COUNT = 24'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       run,
  input  logic       stop,
  input  logic       cfg_valid,
  input  logic [1:0] cfg_mode,
  input  logic [2:0] cfg_speed,
  output logic       cfg_ready,
  output logic [7:0] led_out,
  output logic       step,
  output logic       boundary,
  output logic [1:0] state_o
);
  state_e state_q, state_d;
  mode_e mode_q, mode_d, pmode_q, pmode_d;
  logic [2:0] speed_q, speed_d, pspeed_q, pspeed_d;
  logic pend_q, pend_d, dir_q, dir_d, step_q, step_d, bnd_q, bnd_d;
  logic [7:0] led_q, led_d, nxt;
  logic [CNT_W-1:0] shifted, period;
  logic en, clr, tick, acc;
  led_step_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk), .reset(reset), .en(en), .clr(clr), .period(period), .tick(tick)
  );
  always_comb begin
    shifted = BASE_COUNT >> speed_q;
    period = (shifted == '0) ? CNT_W'(1) : shifted;
    state_d = state_q;
    mode_d = mode_q;
    speed_d = speed_q;
    pmode_d = pmode_q;
    pspeed_d = pspeed_q;
    pend_d = pend_q;
    led_d = led_q;
    dir_d = dir_q;
    step_d = 1'b0;
    bnd_d = 1'b0;
    en = 1'b0;
    clr = 1'b0;
    acc = cfg_valid && !pend_q;
    nxt = next_pattern(mode_q, led_q, dir_q);
    if (stop) begin
      state_d = IDLE;
      led_d = 8'h00;
      pend_d = 1'b0;
      dir_d = 1'b1;
      clr = 1'b1;
    end else if (state_q == IDLE) begin
      clr = 1'b1;
      if (acc) begin
        mode_d = mode_e'(cfg_mode);
        speed_d = cfg_speed;
      end
      if (run) begin
        state_d = RUN;
        led_d = start_pattern(acc ? mode_e'(cfg_mode) : mode_q);
        dir_d = 1'b1;
      end
    end else if (!run) begin
      state_d = PAUSE;
      if (acc) begin
        mode_d = mode_e'(cfg_mode);
        speed_d = cfg_speed;
        led_d = start_pattern(mode_e'(cfg_mode));
        dir_d = 1'b1;
        clr = 1'b1;
      end
    end else begin
      en = 1'b1;
      if (tick) begin
        step_d = 1'b1;
        bnd_d = nxt == start_pattern(mode_q);
        led_d = nxt;
        dir_d = next_dir(nxt, dir_q);
        // A pending config lands exactly where the old pattern would restart.
        if (pend_q && bnd_d) begin
          mode_d = pmode_q;
          speed_d = pspeed_q;
          pend_d = 1'b0;
          led_d = start_pattern(pmode_q);
          dir_d = 1'b1;
        end
      end
      if (acc) begin
        pend_d = 1'b1;
        pmode_d = mode_e'(cfg_mode);
        pspeed_d = cfg_speed;
      end
      state_d = pend_d ? SWITCH : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mode_q <= WALK;
      speed_q <= '0;
      pmode_q <= WALK;
      pspeed_q <= '0;
      pend_q <= 1'b0;
      led_q <= 8'h00;
      dir_q <= 1'b1;
      step_q <= 1'b0;
      bnd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q <= mode_d;
      speed_q <= speed_d;
      pmode_q <= pmode_d;
      pspeed_q <= pspeed_d;
      pend_q <= pend_d;
      led_q <= led_d;
      dir_q <= dir_d;
      step_q <= step_d;
      bnd_q <= bnd_d;
    end
  end
  assign cfg_ready = !pend_q;
  assign led_out = led_q;
  assign step = step_q;
  assign boundary = bnd_q;
  assign state_o = state_q;
endmodule

// File: tb/tb_led_show_controller.sv
// tb_led_show_controller: directed and random checks against a sequence-index model.
module tb_led_show_controller;
  logic clk = 1'b0;
  logic reset = 1'b1, run = 1'b0, stop = 1'b0, cfg_valid = 1'b0;
  logic [1:0] cfg_mode = '0;
  logic [2:0] cfg_speed = '0;
  logic cfg_ready, step, boundary;
  logic [7:0] led_out;
  logic [1:0] state_o;
  int checks = 0, fails = 0;
  int m_state, m_mode, m_speed, m_idx, m_cnt, m_pmode, m_pspeed;
  bit m_pend, m_step, m_bnd;

  led_show_controller #(.CNT_W(24), .BASE_COUNT(24'd8)) dut (
    .clk(clk), .reset(reset), .run(run), .stop(stop), .cfg_valid(cfg_valid),
    .cfg_mode(cfg_mode), .cfg_speed(cfg_speed), .cfg_ready(cfg_ready),
    .led_out(led_out), .step(step), .boundary(boundary), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Patterns as sequences indexed from their start value.
  function automatic int seq_len(int m);
    return m == 0 ? 8 : m == 1 ? 14 : m == 2 ? 9 : 2;
  endfunction
  function automatic logic [7:0] seq_val(int m, int i);
    case (m)
      0: return 8'(1 << i);
      1: return 8'(i <= 7 ? (1 << i) : (1 << (14 - i)));
      2: return 8'((1 << i) - 1);
      default: return i != 0 ? 8'hff : 8'h00;
    endcase
  endfunction
  function automatic int per(int s);
    return (8 >> s) == 0 ? 1 : (8 >> s);
  endfunction
  function automatic logic [12:0] exp_vec();
    return {m_state == 0 ? 8'h00 : seq_val(m_mode, m_idx), m_step, m_bnd, !m_pend, 2'(m_state)};
  endfunction
  function automatic logic [12:0] obs_vec();
    return {led_out, step, boundary, cfg_ready, state_o};
  endfunction

  task automatic model();
    bit acc;
    int nidx;
    acc = cfg_valid && !m_pend;
    m_step = 0;
    m_bnd = 0;
    if (reset) begin
      m_state = 0; m_mode = 0; m_speed = 0; m_idx = 0; m_cnt = 0; m_pend = 0;
    end else if (stop) begin
      m_state = 0; m_idx = 0; m_cnt = 0; m_pend = 0;
    end else if (m_state == 0) begin
      m_cnt = 0;
      if (acc) begin m_mode = cfg_mode; m_speed = cfg_speed; end
      if (run) begin m_state = 1; m_idx = 0; end
    end else if (!run) begin
      m_state = 3;
      if (acc) begin m_mode = cfg_mode; m_speed = cfg_speed; m_idx = 0; m_cnt = 0; end
    end else begin
      if (m_cnt == per(m_speed) - 1) begin
        m_cnt = 0;
        m_step = 1;
        nidx = (m_idx + 1) % seq_len(m_mode);
        m_bnd = nidx == 0;
        m_idx = nidx;
        if (m_pend && nidx == 0) begin
          m_mode = m_pmode; m_speed = m_pspeed; m_pend = 0;
        end
      end else m_cnt++;
      if (acc) begin m_pend = 1; m_pmode = cfg_mode; m_pspeed = cfg_speed; end
      m_state = m_pend ? 2 : 1;
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1; run = 0; stop = 0; cfg_valid = 0;
    cyc();
    reset = 0;
  endtask

  task automatic test_reset();
    reset = 1;
    cyc();
    cyc();
    checks++;
    if (obs_vec() !== 13'b00000000_0_0_1_00) begin
      fails++; $display("FAIL reset: got %h want %h", obs_vec(), 13'b00000000_0_0_1_00);
    end
    reset = 0;
  endtask

  task automatic test_walk();
    int last = -1;
    do_reset();
    run = 1;
    for (int c = 0; c < 70; c++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL walk c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
      if (step) begin
        if (last >= 0) begin
          checks++;
          if (c - last !== 8) begin fails++; $display("FAIL walk_gap: got %0d want 8", c - last); end
        end
        last = c;
      end
    end
  endtask

  task automatic test_bounce();
    int n80 = 0;
    do_reset();
    cfg_valid = 1; cfg_mode = 1; cfg_speed = 3;
    cyc();
    cfg_valid = 0; run = 1;
    cyc();
    for (int c = 0; c < 14; c++) begin
      cyc();
      if (led_out == 8'h80) n80++;
      checks++;
      if (obs_vec() !== exp_vec() || !step) begin
        fails++; $display("FAIL bounce c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (n80 !== 1 || led_out !== 8'h01 || boundary !== 1'b1) begin
      fails++; $display("FAIL bounce_end: got n80=%0d led=%h bnd=%b want 1 01 1", n80, led_out, boundary);
    end
  endtask

  task automatic test_switch();
    bit found = 0;
    do_reset();
    cfg_valid = 1; cfg_mode = 2; cfg_speed = 3;
    cyc();
    cfg_valid = 0; run = 1;
    for (int c = 0; c < 20 && !found; c++) begin
      cyc();
      found = led_out == 8'h07;
    end
    checks++;
    if (!found) begin fails++; $display("FAIL switch_reach: got led=%h want 07", led_out); end
    cfg_valid = 1; cfg_mode = 3; cfg_speed = 3;
    cyc();
    cfg_valid = 0;
    checks++;
    if (state_o !== 2'd2 || cfg_ready !== 1'b0) begin
      fails++; $display("FAIL switch_state: got st=%0d rdy=%b want 2 0", state_o, cfg_ready);
    end
    for (int c = 0; c < 12; c++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL switch c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_pause();
    bit found = 0;
    logic [7:0] held;
    do_reset();
    run = 1;
    for (int c = 0; c < 20 && !found; c++) begin
      cyc();
      found = m_state == 1 && m_cnt == 5;
    end
    held = led_out;
    run = 0;
    for (int c = 0; c < 20; c++) begin
      cyc();
      checks++;
      if (obs_vec() !== exp_vec() || led_out !== held || !found) begin
        fails++; $display("FAIL pause c%0d: got %h want %h held %h", c, obs_vec(), exp_vec(), held);
      end
    end
    run = 1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      checks++;
      if (step !== (k == 3) || obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL resume k%0d: got step=%b %h want step=%b %h", k, step, obs_vec(), k == 3, exp_vec());
      end
    end
  endtask

  task automatic test_stop();
    bit found = 0;
    do_reset();
    run = 1;
    for (int c = 0; c < 20 && !found; c++) begin
      cyc();
      found = m_state == 1 && m_cnt == 7;
    end
    stop = 1; cfg_valid = 1; cfg_mode = 2; cfg_speed = 1;
    cyc();
    stop = 0; cfg_valid = 0;
    checks++;
    if (obs_vec() !== 13'b00000000_0_0_1_00 || !found) begin
      fails++; $display("FAIL stop: got %h want %h", obs_vec(), 13'b00000000_0_0_1_00);
    end
    cyc();
    checks++;
    if (led_out !== 8'h01 || state_o !== 2'd1 || obs_vec() !== exp_vec()) begin
      fails++; $display("FAIL stop_drop: got %h want led 01 %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_clamp_reset();
    do_reset();
    cfg_valid = 1; cfg_mode = 0; cfg_speed = 7;
    cyc();
    cfg_valid = 0; run = 1;
    cyc();
    for (int c = 0; c < 10; c++) begin
      cyc();
      checks++;
      if (!step || obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL clamp c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    reset = 1;
    cyc();
    reset = 0; run = 0;
    checks++;
    if (obs_vec() !== 13'b00000000_0_0_1_00) begin
      fails++; $display("FAIL mid_reset: got %h want %h", obs_vec(), 13'b00000000_0_0_1_00);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      reset = $urandom_range(199) == 0;
      stop = $urandom_range(59) == 0;
      run = $urandom_range(7) != 0;
      cfg_valid = $urandom_range(5) == 0;
      cfg_mode = 2'($urandom);
      cfg_speed = 3'($urandom);
      cyc();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        fails++; $display("FAIL random c%0d: got %h want %h", c, obs_vec(), exp_vec());
      end
    end
    reset = 0; stop = 0; run = 0; cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_walk();
    test_bounce();
    test_switch();
    test_pause();
    test_stop();
    test_clamp_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
